regset_clr: RTL and testbench
=============================

# regset_clr

Parametrised dual-read, single-write register set for the RudolV pipeline, storing an XLEN-bit value plus a TAGW-bit grubby tag per entry in block RAM that has no power-up initialisation. After every reset an internal clear sequencer writes zero to every entry, signalling `ready` when done. It also provides optional write-to-read bypass. It replaces the fixed 64×32+1 register set wherever the target RAM cannot be preloaded.

## Interface
- XLEN, 32, data width per register
- NREGS, 64, number of entries; power of two, ≥2; AW = log2(NREGS)
- TAGW, 1, grubby tag width per entry
- BYPASS, 1, 1 = same-cycle write forwarded to reads; 0 = read-before-write

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- ready  out  1  0 while clearing, 1 once all entries are zero
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- wg  in  TAGW  write tag
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  XLEN  read data, port 1 (registered)
- rg1  out  TAGW  read tag, port 1 (registered)
- rd2  out  XLEN  read data, port 2 (registered)
- rg2  out  TAGW  read tag, port 2 (registered)

## Operation
- Storage: NREGS words of TAGW+XLEN bits, {tag, data}; no other state in the array.
- FSM states CLEAR and RUN.
  - rst=1 at an edge → state CLEAR, clear counter cnt=0, ready=0, rd*/rg*=0.
  - CLEAR: each cycle writes {TAGW'0, XLEN'0} to entry cnt, then cnt+1.
  - In the cycle writing cnt==NREGS-1 → next state RUN; cnt does not wrap.
- CLEAR: we is ignored, with no array write and no later replay. rd*/rg* are held 0 regardless of ra*.
- RUN: if we=1 and wa≠0, {wg, wd} is written to entry wa. Writes with wa=0 are discarded.
- Entry 0 reads as zero data and zero tag on both ports, always.
- Read port n, RUN, per edge:
  - ran=0 → rdn=0, rgn=0.
  - else if BYPASS=1, we=1 and wa=ran → rdn=wd, rgn=wg.
  - else → stored {tag, data} of entry ran, i.e. the value before any same-edge write.
- Each tag travels with its own port's address. rg2 depends only on ra2, never ra1.
- Both ports are independent; ra1=ra2 is legal and returns identical data.

## Timing
- Read latency 1 cycle: address sampled at edge k, data valid after edge k.
- Write visible to a read sampled at a later edge. At the same edge it is visible only with BYPASS=1.
- Clear duration is exactly NREGS cycles. With rst deasserted before edge 1:
  - edges 1..NREGS clear entries 0..NREGS-1;
  - ready=1 after edge NREGS.
- First accepted write and first non-zero read are at edge NREGS+1.
- Reset values: ready=0, rd1=rd2=0, rg1=rg2=0, cnt=0, state CLEAR.
- Array contents are undefined during and before clearing.
- Reset asserted mid-clear or in RUN restarts the clear from cnt=0. The full NREGS cycles are repeated, and all prior contents are lost (zeroed).
- rst held high for multiple cycles: stays at cnt=0 with no array writes. Clearing starts at the first edge with rst=0.
- No combinational path from any input to any output.

## Test plan
- Reset, then read all entries: rst 1 cycle, poll ready → ready rises after exactly NREGS edges. Sweeping ra1/ra2 over 1..NREGS-1 returns rd=0, rg=0 with no X.
- Write/read, tag independence: after ready, write wa=5, wd=0xDEADBEEF, wg=1, and wa=7, wd=0x12345678, wg=0. Next cycles ra1=7, ra2=5 → rd1=0x12345678, rg1=0, rd2=0xDEADBEEF, rg2=1.
- Register 0: write wa=0, wd=0xFFFFFFFF, wg=1; read ra1=ra2=0 → all outputs 0.
- Same-cycle collision: entry 3 holds 0x11; at one edge we=1, wa=3, wd=0x22, ra1=3.
  - BYPASS=1 → rd1=0x22.
  - BYPASS=0 → rd1=0x11, then 0x22 on the next read.
- Writes during clear: assert we with wa=9, wd=0xAA at edges 2..NREGS-1 → after ready, entry 9 reads 0. rd1 stays 0 throughout CLEAR.
- Reset mid-operation: fill entries 1..NREGS-1 with non-zero values. Assert rst during clear at edge NREGS/2, then again in RUN → each time ready drops the same cycle and rises NREGS edges after rst release, and all entries read 0.

Source files
------------

// File: rtl/regset_clr.sv
// regset_clr: dual-read, single-write register set with a {tag, data} word per
// entry. After every reset a clear sequencer zeroes each entry in turn, because
// the storage RAM has no power-up contents. Entry 0 always reads as zero.
module regset_clr #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 64,
  parameter int TAGW   = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int WW    = TAGW + XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [TAGW-1:0] wg,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [TAGW-1:0] rg1,
  output logic [XLEN-1:0] rd2,
  output logic [TAGW-1:0] rg2
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  // Storage word layout is {tag, data}; no reset so it maps onto block RAM.
  logic [WW-1:0]   mem [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [WW-1:0]   mem_wdata;

  logic [WW-1:0]   rdata [2];

  // Next-state logic and the single array write port (clear or user write).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_wa    = wa;
    mem_wdata = {wg, wd};
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = cnt_q;
        mem_wdata = '0;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = RUN;           // counter parks on the last entry
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        mem_we = we && (wa != '0); // entry 0 is hardwired to zero
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    // Reset edges never touch the array; clearing starts after release.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // State and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wdata;
    end
  end

  assign ready = (state_q == RUN);

  // Each read port: raw RAM output (read-before-write) plus registered select
  // flags choosing zero, forwarded write word, or the stored word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [AW-1:0] ra_w;
    logic [WW-1:0] raw_q;
    logic [WW-1:0] byp_word_q, byp_word_d;
    logic          zero_q, zero_d;
    logic          byp_q, byp_d;

    assign ra_w = (gi == 0) ? ra1 : ra2;

    // Registered RAM read; old contents on a same-edge write.
    always_ff @(posedge clk) begin
      raw_q <= mem[ra_w];
    end

    // Decide which source this port presents after the edge.
    always_comb begin
      zero_d     = (state_q != RUN) || (ra_w == '0);
      byp_d      = (BYPASS != 0) && we && (wa == ra_w);
      byp_word_d = {wg, wd};
    end

    // Select flags reset to "zero" so outputs are 0 straight out of reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        zero_q     <= 1'b1;
        byp_q      <= 1'b0;
        byp_word_q <= '0;
      end else begin
        zero_q     <= zero_d;
        byp_q      <= byp_d;
        byp_word_q <= byp_word_d;
      end
    end

    assign rdata[gi] = zero_q ? '0 : (byp_q ? byp_word_q : raw_q);
  end

  assign rd1 = rdata[0][XLEN-1:0];
  assign rg1 = rdata[0][WW-1:XLEN];
  assign rd2 = rdata[1][XLEN-1:0];
  assign rg2 = rdata[1][WW-1:XLEN];

endmodule

// File: tb/tb_regset_clr.sv
// Bench for regset_clr: one instance with bypass and one without share the
// same stimulus; both are compared every cycle against an array-based model.
module tb_regset_clr;
  localparam int XLEN  = 32;
  localparam int NREGS = 64;
  localparam int TAGW  = 1;
  localparam int AW    = 6;
  localparam int WW    = TAGW + XLEN;

  logic clk = 1'b0;
  logic rst, we;
  logic [AW-1:0] wa, ra1, ra2;
  logic [XLEN-1:0] wd;
  logic [TAGW-1:0] wg;

  logic ready_b, ready_n;
  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [TAGW-1:0] rg1_b, rg2_b, rg1_n, rg2_n;

  regset_clr #(.XLEN(XLEN), .NREGS(NREGS), .TAGW(TAGW), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .we(we), .wa(wa), .wd(wd), .wg(wg),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rg1(rg1_b), .rd2(rd2_b), .rg2(rg2_b));

  regset_clr #(.XLEN(XLEN), .NREGS(NREGS), .TAGW(TAGW), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .ready(ready_n), .we(we), .wa(wa), .wd(wd), .wg(wg),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rg1(rg1_n), .rd2(rd2_n), .rg2(rg2_n));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: contents as seen after clearing, and cycles of clear left.
  logic [WW-1:0] model [NREGS];
  int clear_left = NREGS;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WW-1:0] expect_rd(input bit byp, input logic [AW-1:0] ra);
    if (clear_left > 0 || ra == 0) return '0;
    if (byp && we && wa == ra) return {wg, wd};
    return model[ra];
  endfunction

  // Apply one cycle of inputs, predict, clock, then compare both instances.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [XLEN-1:0] d, input logic [TAGW-1:0] g,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic [WW-1:0] e1b, e2b, e1n, e2n;
    bit exp_ready;
    rst = r; we = w; wa = a; wd = d; wg = g; ra1 = r1; ra2 = r2;
    if (r) begin
      e1b = '0; e2b = '0; e1n = '0; e2n = '0;
      clear_left = NREGS;
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else begin
      e1b = expect_rd(1'b1, r1); e2b = expect_rd(1'b1, r2);
      e1n = expect_rd(1'b0, r1); e2n = expect_rd(1'b0, r2);
      if (clear_left > 0) clear_left--;
      else if (w && a != 0) model[a] = {g, d};
    end
    exp_ready = (clear_left == 0);
    @(posedge clk);
    #1;
    chk("ready_byp", 64'(ready_b), 64'(exp_ready));
    chk("port1_byp", 64'({rg1_b, rd1_b}), 64'(e1b));
    chk("port2_byp", 64'({rg2_b, rd2_b}), 64'(e2b));
    chk("ready_nobyp", 64'(ready_n), 64'(exp_ready));
    chk("port1_nobyp", 64'({rg1_n, rd1_n}), 64'(e1n));
    chk("port2_nobyp", 64'({rg2_n, rd2_n}), 64'(e2n));
  endtask

  // Idle until ready, bounded; the number of edges must equal NREGS.
  task automatic wait_ready(input string name);
    int n = 0;
    while (ready_b !== 1'b1 && n < 4 * NREGS) begin
      step(1'b0, 1'b0, '0, '0, '0, AW'($urandom), AW'($urandom));
      n++;
    end
    chk(name, 64'(n), 64'(NREGS));
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [TAGW-1:0] wg;
    logic [AW-1:0]   ra1, ra2;
    logic [XLEN-1:0] rd1, rd2;
    logic [TAGW-1:0] rg1, rg2;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 6'd7, 32'h12345678, 1'b0, 6'd5, 6'd3, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd7, 6'd5, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 6'd0, 32'hFFFFFFFF, 1'b1, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 6'd3, 32'h11, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 6'd3, 32'h22, 1'b1, 6'd3, 6'd3, 32'h22, 32'h22, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd3, 6'd7, 32'h22, 32'h12345678, 1'b1, 1'b0};

    // Reset, clear length, then sweep every entry on both ports.
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    wait_ready("clear_len_first");
    for (int i = 1; i < NREGS; i++) step(1'b0, 1'b0, '0, '0, '0, AW'(i), AW'(NREGS - i));

    // Directed table: tag independence, entry 0, same-edge collision.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wg, tbl[i].ra1, tbl[i].ra2);
      chk($sformatf("tbl%0d_rd1", i), 64'(rd1_b), 64'(tbl[i].rd1));
      chk($sformatf("tbl%0d_rg1", i), 64'(rg1_b), 64'(tbl[i].rg1));
      chk($sformatf("tbl%0d_rd2", i), 64'(rd2_b), 64'(tbl[i].rd2));
      chk($sformatf("tbl%0d_rg2", i), 64'(rg2_b), 64'(tbl[i].rg2));
      if (i == 6) chk("collide_nobyp_old", 64'(rd1_n), 64'h11);
      if (i == 7) chk("collide_nobyp_new", 64'(rd1_n), 64'h22);
    end

    // Writes attempted during clear are dropped; port 1 stays 0 throughout.
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    for (int e = 1; e <= NREGS; e++) begin
      step(1'b0, (e >= 2 && e <= NREGS - 1), 6'd9, 32'hAA, 1'b1, 6'd9, 6'd9);
    end
    step(1'b0, 1'b0, '0, '0, '0, 6'd9, 6'd9);
    chk("clear_write_dropped", 64'({rg1_b, rd1_b}), 64'h0);

    // Fill, reset mid-clear, refill, reset in RUN; contents must be zero.
    for (int i = 1; i < NREGS; i++) step(1'b0, 1'b1, AW'(i), $urandom | 32'h1, 1'b1, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < NREGS / 2; i++) step(1'b0, 1'b0, '0, '0, '0, AW'(i), AW'(i));
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    chk("ready_drop_midclear", 64'(ready_b), 64'h0);
    wait_ready("clear_len_midclear");
    for (int i = 1; i < NREGS; i++) step(1'b0, 1'b1, AW'(i), $urandom | 32'h1, 1'b1, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    chk("ready_drop_run", 64'(ready_b), 64'h0);
    wait_ready("clear_len_run");
    for (int i = 1; i < NREGS; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, AW'(i), AW'(i));
      chk("sweep_zero", 64'({rg1_b, rd1_b, rg2_n, rd2_n}), 64'h0);
    end

    // Randomised traffic with narrow address range for frequent collisions.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) == 0), $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 15)), $urandom, TAGW'($urandom),
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
